// File: rtl/spi_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : spi_cmd_arbiter
// Description : Shares the 5-byte SPI register-access front end
//               (cmdUpdate/cmd/addr/data) between NUM_REQ requesters.
//               Requests are granted round-robin. Each grant issues one
//               cmdUpdate strobe. Completion is detected from the SPI
//               chip-select, and a per-requester done pulse is returned
//               together with a timeout flag.
//
// Ports
//   clk40M       in   1           system clock
//   nRst         in   1           asynchronous active-low reset
//   req_valid    in   NUM_REQ     per-requester request, held until req_ack
//   req_word     in   NUM_REQ*40  per-requester command words; slice i is
//                                 {dataMsb,dataLsb,addrMsb,addrLsb,cmd}
//   req_ack      out  NUM_REQ     one-hot pulse: request accepted, word latched
//   req_done     out  NUM_REQ     one-hot pulse: transaction finished
//   req_timeout  out  1           qualifies req_done: 1 = ended by timeout
//   busy         out  1           high from grant until the end of GAP
//   cmdUpdate    out  1           1-cycle strobe to the SPI top
//   o_cmd .. o_dataMsb out 8 each latched command bytes
//   spi_cs_n     in   1           SPI chip-select (same clock domain)
//
// Revision    : 1.0  initial release
// ============================================================================
module spi_cmd_arbiter #(
    parameter int NUM_REQ       = 3,
    parameter int START_TIMEOUT = 16,
    parameter int XFER_TIMEOUT  = 1024,
    parameter int GAP_CLKS      = 4
) (
    input  logic                  clk40M,
    input  logic                  nRst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*40-1:0] req_word,
    output logic [NUM_REQ-1:0]    req_ack,
    output logic [NUM_REQ-1:0]    req_done,
    output logic                  req_timeout,
    output logic                  busy,
    output logic                  cmdUpdate,
    output logic [7:0]            o_cmd,
    output logic [7:0]            o_addrLsb,
    output logic [7:0]            o_addrMsb,
    output logic [7:0]            o_dataLsb,
    output logic [7:0]            o_dataMsb,
    input  logic                  spi_cs_n
);

    localparam int c_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_MAX_A = (START_TIMEOUT > XFER_TIMEOUT) ? START_TIMEOUT : XFER_TIMEOUT;
    localparam int c_MAX   = (c_MAX_A > GAP_CLKS) ? c_MAX_A : GAP_CLKS;
    localparam int c_CNT_W = $clog2(c_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE         = 3'd0,
        S_ISSUE        = 3'd1,
        S_WAIT_CS_LOW  = 3'd2,
        S_WAIT_CS_HIGH = 3'd3,
        S_GAP          = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_next;
    logic [c_IDX_W-1:0]   r_last_grant;
    logic [c_IDX_W-1:0]   r_grant;
    logic [c_IDX_W-1:0]   w_winner;
    logic                 w_found;
    logic [39:0]          r_word;
    logic [NUM_REQ-1:0]   r_ack;
    logic [NUM_REQ-1:0]   r_done;
    logic                 r_timeout;
    logic [NUM_REQ-1:0]   w_ack_next;
    logic [NUM_REQ-1:0]   w_done_next;
    logic                 w_timeout_next;
    logic [NUM_REQ-1:0]   w_grant_oh;
    logic [NUM_REQ-1:0]   w_upper;
    logic [39:0]          w_words [NUM_REQ];

    // Split the flat word bus per requester, and mark the requesters that
    // sit above the last grant (they are searched first).
    generate
        for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
            assign w_words[g] = req_word[40*g +: 40];
            assign w_upper[g] = (c_IDX_W'(g) > r_last_grant);
        end
    endgenerate

    // Round-robin pick: lowest active requester above the last grant,
    // otherwise wrap around to the lowest active requester overall.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                w_found  = 1'b1;
                w_winner = c_IDX_W'(i);
            end
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i] && w_upper[i]) begin
                w_winner = c_IDX_W'(i);
            end
        end
    end

    assign w_grant_oh = NUM_REQ'(1) << r_grant;

    // Next-state logic. ack/done are computed here and registered, so the
    // pulses coincide with the first cycle of the destination state.
    always_comb begin
        w_state_next   = r_state;
        w_ack_next     = '0;
        w_done_next    = '0;
        w_timeout_next = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_next = S_ISSUE;
                    w_ack_next   = NUM_REQ'(1) << w_winner;
                end
            end
            S_ISSUE: begin
                w_state_next = S_WAIT_CS_LOW;
            end
            S_WAIT_CS_LOW: begin
                if (!spi_cs_n) begin
                    w_state_next = S_WAIT_CS_HIGH;
                end else if (r_cnt == c_CNT_W'(START_TIMEOUT - 1)) begin
                    // SPI top never started (e.g. command it ignores)
                    w_state_next   = S_GAP;
                    w_done_next    = w_grant_oh;
                    w_timeout_next = 1'b1;
                end
            end
            S_WAIT_CS_HIGH: begin
                if (spi_cs_n) begin
                    w_state_next = S_GAP;
                    w_done_next  = w_grant_oh;
                end else if (r_cnt == c_CNT_W'(XFER_TIMEOUT - 1)) begin
                    w_state_next   = S_GAP;
                    w_done_next    = w_grant_oh;
                    w_timeout_next = 1'b1;
                end
            end
            S_GAP: begin
                if (r_cnt == c_CNT_W'(GAP_CLKS - 1)) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // One shared counter: cleared on every state change, counting only in
    // the states that time something.
    always_comb begin
        w_cnt_next = '0;
        if (w_state_next == r_state) begin
            if ((r_state == S_WAIT_CS_LOW) || (r_state == S_WAIT_CS_HIGH) ||
                (r_state == S_GAP)) begin
                w_cnt_next = r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk40M or negedge nRst) begin
        if (!nRst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_last_grant <= c_IDX_W'(NUM_REQ - 1);  // requester 0 searched first
            r_grant      <= '0;
            r_word       <= '0;
            r_ack        <= '0;
            r_done       <= '0;
            r_timeout    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_ack     <= w_ack_next;
            r_done    <= w_done_next;
            r_timeout <= w_timeout_next;
            if ((r_state == S_IDLE) && w_found) begin
                r_grant      <= w_winner;
                r_last_grant <= w_winner;
                r_word       <= w_words[w_winner];
            end
        end
    end

    assign req_ack     = r_ack;
    assign req_done    = r_done;
    assign req_timeout = r_timeout;
    assign busy        = (r_state != S_IDLE);
    assign cmdUpdate   = (r_state == S_ISSUE);
    assign o_cmd       = r_word[7:0];
    assign o_addrLsb   = r_word[15:8];
    assign o_addrMsb   = r_word[23:16];
    assign o_dataLsb   = r_word[31:24];
    assign o_dataMsb   = r_word[39:32];

endmodule
`default_nettype wire

// File: tb/tb_spi_cmd_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_spi_cmd_arbiter
// Description : Directed self-checking bench for spi_cmd_arbiter.
// Revision    : 1.0  initial release
// ============================================================================
module tb_spi_cmd_arbiter;

    localparam int NR = 3;
    localparam int ST = 16;
    localparam int XT = 1024;
    localparam int GC = 4;

    logic          clk40M = 1'b0;
    logic          nRst = 1'b0;
    logic [NR-1:0] req_valid = '0;
    logic [39:0]   w0 = '0;
    logic [39:0]   w1 = '0;
    logic [39:0]   w2 = '0;
    logic [NR*40-1:0] req_word;
    logic [NR-1:0] req_ack;
    logic [NR-1:0] req_done;
    logic          req_timeout;
    logic          busy;
    logic          cmdUpdate;
    logic [7:0]    o_cmd, o_addrLsb, o_addrMsb, o_dataLsb, o_dataMsb;
    logic          spi_cs_n = 1'b1;

    int errors = 0;
    int checks = 0;

    assign req_word = {w2, w1, w0};

    always #12.5 clk40M = ~clk40M;

    spi_cmd_arbiter #(
        .NUM_REQ(NR), .START_TIMEOUT(ST), .XFER_TIMEOUT(XT), .GAP_CLKS(GC)
    ) dut (
        .clk40M(clk40M), .nRst(nRst), .req_valid(req_valid), .req_word(req_word),
        .req_ack(req_ack), .req_done(req_done), .req_timeout(req_timeout),
        .busy(busy), .cmdUpdate(cmdUpdate), .o_cmd(o_cmd), .o_addrLsb(o_addrLsb),
        .o_addrMsb(o_addrMsb), .o_dataLsb(o_dataLsb), .o_dataMsb(o_dataMsb),
        .spi_cs_n(spi_cs_n)
    );

    task automatic tick();
        @(posedge clk40M);
        #1;
    endtask

    task automatic wait_ack(input int budget, output int n);
        n = 0;
        while (req_ack == '0 && n < budget) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        while (req_done == '0 && n < budget) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        nRst = 1'b0;
        tick();
        tick();
        checks++; if (req_ack !== 3'b000) begin errors++; $display("FAIL reset_ack: got %b expected 000", req_ack); end
        checks++; if (req_done !== 3'b000) begin errors++; $display("FAIL reset_done: got %b expected 000", req_done); end
        checks++; if (req_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", req_timeout); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (cmdUpdate !== 1'b0) begin errors++; $display("FAIL reset_cmdUpdate: got %b expected 0", cmdUpdate); end
        checks++; if ({o_dataMsb, o_dataLsb, o_addrMsb, o_addrLsb, o_cmd} !== 40'h0) begin
            errors++; $display("FAIL reset_bytes: got %h expected 0000000000",
                               {o_dataMsb, o_dataLsb, o_addrMsb, o_addrLsb, o_cmd});
        end
        nRst = 1'b1;
        tick();
    endtask

    task automatic test_single();
        w0 = 40'h34120201A1;
        req_valid = 3'b001;
        tick();
        checks++; if (req_ack !== 3'b001) begin errors++; $display("FAIL single_ack: got %b expected 001", req_ack); end
        checks++; if (cmdUpdate !== 1'b1) begin errors++; $display("FAIL single_cmdUpdate: got %b expected 1", cmdUpdate); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", busy); end
        checks++; if ({o_dataMsb, o_dataLsb, o_addrMsb, o_addrLsb, o_cmd} !== 40'h34120201A1) begin
            errors++; $display("FAIL single_bytes: got %h expected 34120201a1",
                               {o_dataMsb, o_dataLsb, o_addrMsb, o_addrLsb, o_cmd});
        end
        req_valid = 3'b000;
        tick();
        checks++; if ({req_ack, cmdUpdate} !== 4'b0000) begin errors++; $display("FAIL single_pulse_width: got %b expected 0000", {req_ack, cmdUpdate}); end
        tick();
        tick();
        spi_cs_n = 1'b0;
        repeat (20) tick();
        checks++; if (req_done !== 3'b000) begin errors++; $display("FAIL single_early_done: got %b expected 000", req_done); end
        spi_cs_n = 1'b1;
        tick();
        checks++; if (req_done !== 3'b001) begin errors++; $display("FAIL single_done: got %b expected 001", req_done); end
        checks++; if (req_timeout !== 1'b0) begin errors++; $display("FAIL single_timeout: got %b expected 0", req_timeout); end
        tick();
        checks++; if (req_done !== 3'b000) begin errors++; $display("FAIL single_done_width: got %b expected 000", req_done); end
        repeat (GC - 2) tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_gap_busy: got %b expected 1", busy); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_round_robin();
        int n;
        logic [2:0] exp_ack;
        logic [7:0] exp_cmd;
        nRst = 1'b0;
        tick();
        nRst = 1'b1;
        tick();
        w0 = 40'h0000000010;
        w1 = 40'h0000000011;
        w2 = 40'h0000000012;
        req_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            exp_ack = 3'b001 << (k % 3);
            exp_cmd = 8'h10 + 8'(k % 3);
            wait_ack(20, n);
            checks++; if (req_ack !== exp_ack) begin errors++; $display("FAIL rr_ack[%0d]: got %b expected %b", k, req_ack, exp_ack); end
            checks++; if (o_cmd !== exp_cmd) begin errors++; $display("FAIL rr_cmd[%0d]: got %h expected %h", k, o_cmd, exp_cmd); end
            tick();
            spi_cs_n = 1'b0;
            repeat (5) tick();
            spi_cs_n = 1'b1;
            wait_done(10, n);
        end
        req_valid = 3'b000;
        wait_idle(20);
    endtask

    task automatic test_start_timeout();
        int n;
        int cu;
        int early;
        w1 = 40'h0000000055;
        req_valid = 3'b010;
        wait_ack(10, n);
        checks++; if (req_ack !== 3'b010) begin errors++; $display("FAIL st_ack: got %b expected 010", req_ack); end
        req_valid = 3'b000;
        tick();
        cu = 0;
        early = 0;
        repeat (ST - 1) begin
            tick();
            if (cmdUpdate) cu++;
            if (req_done != '0) early++;
        end
        checks++; if (early !== 0) begin errors++; $display("FAIL st_early_done: got %0d expected 0", early); end
        checks++; if (cu !== 0) begin errors++; $display("FAIL st_extra_cmdUpdate: got %0d expected 0", cu); end
        tick();
        checks++; if (req_done !== 3'b010) begin errors++; $display("FAIL st_done: got %b expected 010", req_done); end
        checks++; if (req_timeout !== 1'b1) begin errors++; $display("FAIL st_timeout: got %b expected 1", req_timeout); end
        wait_idle(20);
    endtask

    task automatic test_xfer_timeout();
        int n;
        w0 = 40'h0000000020;
        w2 = 40'h0000000022;
        req_valid = 3'b101;
        wait_ack(10, n);
        checks++; if (req_ack !== 3'b100) begin errors++; $display("FAIL xt_ack: got %b expected 100", req_ack); end
        req_valid = 3'b001;
        spi_cs_n = 1'b0;
        tick();
        tick();
        wait_done(XT + 10, n);
        checks++; if (n !== XT) begin errors++; $display("FAIL xt_cycles: got %0d expected %0d", n, XT); end
        checks++; if (req_done !== 3'b100) begin errors++; $display("FAIL xt_done: got %b expected 100", req_done); end
        checks++; if (req_timeout !== 1'b1) begin errors++; $display("FAIL xt_timeout: got %b expected 1", req_timeout); end
        spi_cs_n = 1'b1;
        wait_ack(20, n);
        checks++; if (n !== GC + 1) begin errors++; $display("FAIL xt_gap_cycles: got %0d expected %0d", n, GC + 1); end
        checks++; if (req_ack !== 3'b001) begin errors++; $display("FAIL xt_next_ack: got %b expected 001", req_ack); end
        req_valid = 3'b000;
        wait_done(ST + 5, n);
        wait_idle(20);
    endtask

    task automatic test_reset_mid();
        int n;
        int seen;
        w1 = 40'h0000000031;
        req_valid = 3'b010;
        wait_ack(10, n);
        checks++; if (req_ack !== 3'b010) begin errors++; $display("FAIL rm_ack: got %b expected 010", req_ack); end
        req_valid = 3'b000;
        spi_cs_n = 1'b0;
        repeat (5) tick();
        #5;
        nRst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_async_busy: got %b expected 0", busy); end
        checks++; if ({req_ack, req_done, req_timeout, cmdUpdate} !== 8'h00) begin
            errors++; $display("FAIL rm_async_pulses: got %b expected 00000000", {req_ack, req_done, req_timeout, cmdUpdate});
        end
        checks++; if (o_cmd !== 8'h00) begin errors++; $display("FAIL rm_async_cmd: got %h expected 00", o_cmd); end
        spi_cs_n = 1'b1;
        seen = 0;
        repeat (2) begin
            tick();
            if (req_done != '0) seen++;
        end
        nRst = 1'b1;
        repeat (4) begin
            tick();
            if (req_done != '0) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rm_no_done: got %0d expected 0", seen); end
        req_valid = 3'b111;
        wait_ack(5, n);
        checks++; if (req_ack !== 3'b001) begin errors++; $display("FAIL rm_priority: got %b expected 001", req_ack); end
        req_valid = 3'b000;
        wait_done(ST + 5, n);
        wait_idle(20);
    endtask

    task automatic test_withdrawn();
        int n;
        int acks;
        w0 = 40'h00000000A1;
        req_valid = 3'b001;
        wait_ack(10, n);
        checks++; if (req_ack !== 3'b001) begin errors++; $display("FAIL wd_ack0: got %b expected 001", req_ack); end
        req_valid = 3'b010;
        tick();
        tick();
        req_valid = 3'b000;
        acks = 0;
        repeat (60) begin
            tick();
            if (req_ack != '0) acks++;
        end
        checks++; if (acks !== 0) begin errors++; $display("FAIL wd_no_ack: got %0d expected 0", acks); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wd_idle: got %b expected 0", busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_start_timeout();
        test_xfer_timeout();
        test_reset_mid();
        test_withdrawn();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
